// File: rtl/dnn_fix8_relu_engine.sv
// Two-layer Q3.4 MNIST engine: a ReLU hidden layer, then a linear output layer,
// one multiply-accumulate per clock against a combinational-read external memory.
module dnn_fix8_relu_engine #(
    parameter int N_IN   = 784,
    parameter int N_HID  = 64,
    parameter int N_OUT  = 10,
    parameter int FRAC   = 4,
    parameter int X_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reset,
    output logic              done,
    output logic [15:0]       mem_addr,
    input  logic signed [7:0] mem_data,
    output logic signed [7:0] out [N_OUT-1:0]
);
    localparam int W1_BASE = X_BASE + N_IN;
    localparam int B1_BASE = W1_BASE + N_IN * N_HID;
    localparam int W2_BASE = B1_BASE + N_HID;
    localparam int B2_BASE = W2_BASE + N_HID * N_OUT;
    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_L1, S_L2, S_DONE} state_t;
    typedef enum logic [1:0] {P_BIAS, P_MAC, P_STORE} phase_t;

    state_t             state_reg, state_next;
    phase_t             phase_reg, phase_next;
    logic [15:0]        idx_reg, idx_next;
    logic [15:0]        nrn_reg, nrn_next;
    logic signed [31:0] acc_reg;
    logic signed [7:0]  x_mem [N_IN];
    logic signed [7:0]  h_mem [N_HID];

    logic [15:0]        last_idx, last_nrn;
    int                 addr_calc;
    logic signed [7:0]  operand;
    logic signed [15:0] prod;
    logic signed [31:0] acc_shift;
    logic signed [7:0]  sat_val, relu_val;

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)       return 8'h7f;
        else if (v < -32'sd128) return 8'h80;
        else                    return v[7:0];
    endfunction

    always_comb begin
        last_idx   = (state_reg == S_L1) ? 16'(N_IN - 1)  : 16'(N_HID - 1);
        last_nrn   = (state_reg == S_L1) ? 16'(N_HID - 1) : 16'(N_OUT - 1);
        state_next = state_reg;
        phase_next = phase_reg;
        idx_next   = idx_reg;
        nrn_next   = nrn_reg;
        if (reset) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (start) begin
                    state_next = S_PRE;
                    idx_next   = '0;
                end
                S_PRE: if (idx_reg == 16'(N_IN - 1)) begin
                    state_next = S_L1;
                    phase_next = P_BIAS;
                    nrn_next   = '0;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 16'd1;
                end
                S_L1, S_L2: case (phase_reg)
                    P_BIAS: begin
                        phase_next = P_MAC;
                        idx_next   = '0;
                    end
                    P_MAC: if (idx_reg == last_idx) phase_next = P_STORE;
                           else idx_next = idx_reg + 16'd1;
                    default: begin
                        phase_next = P_BIAS;
                        if (nrn_reg == last_nrn) begin
                            nrn_next   = '0;
                            state_next = (state_reg == S_L1) ? S_L2 : S_DONE;
                        end else begin
                            nrn_next = nrn_reg + 16'd1;
                        end
                    end
                endcase
                S_DONE:  state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // mem_addr is registered, so it is derived from the step about to execute.
    always_comb begin
        addr_calc = 0;
        case (state_next)
            S_PRE: addr_calc = X_BASE + int'(idx_next);
            S_L1: begin
                if (phase_next == P_BIAS)     addr_calc = B1_BASE + int'(nrn_next);
                else if (phase_next == P_MAC) addr_calc = W1_BASE + int'(nrn_next) * N_IN + int'(idx_next);
            end
            S_L2: begin
                if (phase_next == P_BIAS)     addr_calc = B2_BASE + int'(nrn_next);
                else if (phase_next == P_MAC) addr_calc = W2_BASE + int'(nrn_next) * N_HID + int'(idx_next);
            end
            default: addr_calc = 0;
        endcase
    end

    always_comb begin
        operand   = (state_reg == S_L1) ? x_mem[idx_reg[IW-1:0]] : h_mem[idx_reg[HW-1:0]];
        prod      = mem_data * operand;
        acc_shift = acc_reg >>> FRAC;
        sat_val   = sat8(acc_shift);
        relu_val  = sat_val[7] ? 8'sd0 : sat_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            phase_reg <= P_BIAS;
            idx_reg   <= '0;
            nrn_reg   <= '0;
            mem_addr  <= '0;
            done      <= 1'b0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            idx_reg   <= idx_next;
            nrn_reg   <= nrn_next;
            mem_addr  <= 16'(addr_calc);
            if (reset)                   done <= 1'b0;
            else if (state_reg == S_DONE) done <= 1'b1;
            if (!reset && (state_reg == S_L1 || state_reg == S_L2)) begin
                if (phase_reg == P_BIAS)     acc_reg <= 32'(mem_data) <<< FRAC;
                else if (phase_reg == P_MAC) acc_reg <= acc_reg + 32'(prod);
            end
        end
    end

    // Image and hidden activations survive a soft clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset && state_reg == S_PRE)
            x_mem[idx_reg[IW-1:0]] <= mem_data;
        if (!reset && state_reg == S_L1 && phase_reg == P_STORE)
            h_mem[nrn_reg[HW-1:0]] <= relu_val;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    out[gi] <= '0;
                else if (reset)
                    out[gi] <= '0;
                else if (state_reg == S_L2 && phase_reg == P_STORE && nrn_reg == 16'(gi))
                    out[gi] <= sat_val;
            end
        end
    endgenerate
endmodule

// File: tb/tb_dnn_fix8_relu_engine.sv
// Bench for dnn_fix8_relu_engine at reduced sizes; a plain-arithmetic model of
// the two-layer network supplies every expected output and the done latency.
module tb_dnn_fix8_relu_engine;
    localparam int NI  = 12;
    localparam int NH  = 5;
    localparam int NO  = 10;
    localparam int FR  = 4;
    localparam int XB  = 3;
    localparam int W1B = XB + NI;
    localparam int B1B = W1B + NI * NH;
    localparam int W2B = B1B + NH;
    localparam int B2B = W2B + NH * NO;
    localparam int LAT = NI + NH * (NI + 2) + NO * (NH + 2) + 1;

    logic              clk = 1'b0;
    logic              rst, start, reset;
    logic              done;
    logic [15:0]       mem_addr;
    logic signed [7:0] mem_data;
    logic signed [7:0] out_w [NO-1:0];
    logic signed [7:0] mem [0:65535];
    int                n_cmp = 0, n_fail = 0;
    int                exp_out [NO];

    always #5 clk = ~clk;
    assign mem_data = mem[mem_addr];

    dnn_fix8_relu_engine #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .FRAC(FR), .X_BASE(XB)) dut (
        .clk(clk), .rst(rst), .start(start), .reset(reset), .done(done),
        .mem_addr(mem_addr), .mem_data(mem_data), .out(out_w)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int a);
        int d = 1 << FR;
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    function automatic int clamp8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    task automatic model();
        int h [NH];
        int s;
        for (int j = 0; j < NH; j++) begin
            s = int'(mem[B1B + j]) * (1 << FR);
            for (int i = 0; i < NI; i++)
                s += int'(mem[W1B + j * NI + i]) * int'(mem[XB + i]);
            h[j] = clamp8(floor_div(s));
            if (h[j] < 0) h[j] = 0;
        end
        for (int k = 0; k < NO; k++) begin
            s = int'(mem[B2B + k]) * (1 << FR);
            for (int j = 0; j < NH; j++)
                s += int'(mem[W2B + k * NH + j]) * h[j];
            exp_out[k] = clamp8(floor_div(s));
        end
    endtask

    task automatic fill(input int xv, input int w1v, input int b1v, input int w2v, input int b2v);
        for (int a = XB; a < W1B; a++)      mem[a] = 8'(xv);
        for (int a = W1B; a < B1B; a++)     mem[a] = 8'(w1v);
        for (int a = B1B; a < W2B; a++)     mem[a] = 8'(b1v);
        for (int a = W2B; a < B2B; a++)     mem[a] = 8'(w2v);
        for (int a = B2B; a < B2B + NO; a++) mem[a] = 8'(b2v);
    endtask

    task automatic fill_rand(input int span);
        for (int a = XB; a < B2B + NO; a++)
            mem[a] = 8'(int'($urandom_range(0, 2 * span)) - span);
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < NO; k++)
            check($sformatf("%s out[%0d]", tag, k), out_w[k], exp_out[k]);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " done"}, done, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        for (int k = 0; k < NO; k++)
            check($sformatf("%s clr out[%0d]", tag, k), out_w[k], 0);
    endtask

    // Soft clear, then start in the very next cycle; returns just after edge 0.
    task automatic launch(input string tag);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) begin reset = 1'b0; start = 1'b1; end
        check_cleared(tag);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int glitch_at);
        int lat = -1;
        for (int n = 1; n <= 4 * LAT; n++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = n; break; end
            start = (n == glitch_at);
        end
        start = 1'b0;
        check({tag, " latency"}, lat, LAT);
    endtask

    task automatic run(input string tag, input int glitch_at);
        model();
        launch(tag);
        wait_done(tag, glitch_at);
        check_outs(tag);
        $display("run %s: out0=%0d out9=%0d done=%0d", tag, out_w[0], out_w[NO-1], done);
    endtask

    initial begin
        int best, label;
        rst = 1'b0; start = 1'b0; reset = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'sd0;

        @(negedge clk);
        @(negedge clk);
        check_cleared("por");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("idle");

        run("zero", -1);

        fill(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) mem[B2B + k] = 8'(16 * k);
        run("bias", -1);
        best = 0; label = 0;
        for (int k = 0; k < NO; k++)
            if (out_w[k] > best) begin best = out_w[k]; label = k + 1; end
        check("bias argmax", label, 8);

        fill(16, -16, 0, 16, 0);
        run("relu_neg", -1);
        check("relu_neg out3", out_w[3], 0);

        fill(16, 16, 0, 16, 0);
        run("relu_sat", -1);
        check("relu_sat out5", out_w[5], 127);

        fill(127, 127, 0, -128, 0);
        run("neg_sat", -1);
        check("neg_sat out9", out_w[9], -128);

        fill_rand(128); run("rand_full", -1);
        fill_rand(24);  run("rand_small0", -1);
        fill_rand(12);  run("rand_small1", -1);

        fill_rand(20);
        run("start_glitch", 30);

        fill_rand(20);
        launch("abort_l1");
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_cleared("abort_l1 after");
        repeat (3) @(posedge clk);
        #1 check("abort_l1 idle mem_addr", mem_addr, 0);
        run("after_abort_l1", -1);

        fill_rand(16);
        model();
        launch("abort_l2");
        repeat (140) @(posedge clk);
        #1 check("abort_l2 partial out0", out_w[0], exp_out[0]);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_cleared("abort_l2 after");
        run("after_abort_l2", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
